// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared state encodings, default IDs and size helper for axi_req_arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
  localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;
  // icache refills are always full 32-bit words
  localparam logic [1:0] INST_SIZE = 2'd2;

  function automatic logic [2:0] to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_req_arbiter_if.sv
// rtl/axi_req_arbiter_if.sv - variable AXI AR/R/AW/W/B fields driven or consumed by the arbiter
interface axi_req_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_chan.sv
// rtl/axi_wr_chan.sv - single-beat data write sequencer over AW/W/B with independent AW and W handshakes
module axi_wr_chan
  import axi_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  input  logic        b_hold_i,
  output logic        idle_o,
  output logic        done_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  wr_state_e   w_state_q, w_state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] waddr_q, waddr_d;
  logic [1:0]  wsize_q, wsize_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      waddr_q   <= '0;
      wsize_q   <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      waddr_q   <= waddr_d;
      wsize_q   <= wsize_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    waddr_d   = waddr_q;
    wsize_d   = wsize_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    done_o    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (accept_i) begin
          waddr_d   = addr_i;
          wsize_d   = size_i;
          wstrb_d   = wstrb_i;
          wdata_d   = wdata_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_SEND;
        end
      end
      W_SEND: begin
        awvalid_o = ~aw_done_q;
        wvalid_o  = ~w_done_q;
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q | wready_i;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        // hold off B while a data read beat owns data_data_ok this cycle
        bready_o = ~b_hold_i;
        if (bvalid_i && !b_hold_i) begin
          done_o    = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign idle_o   = (w_state_q == W_IDLE);
  assign awaddr_o = waddr_q;
  assign awsize_o = to_axsize(wsize_q);
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;

endmodule

// File: rtl/axi_req_arbiter.sv
// rtl/axi_req_arbiter.sv - inst/data SRAM-like to AXI arbiter; RAW_ADDR_CHECK_EN lets data reads overlap writes to other words
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic [3:0] INST_ID    = INST_ID_DEFAULT,
  parameter logic [3:0] DATA_ID    = DATA_ID_DEFAULT,
  parameter bit         DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [7:0]  inst_len,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_rlast,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  axi_req_arbiter_if.master axi
);

  rd_state_e   r_state_q, r_state_d;
  logic [31:0] raddr_q, raddr_d;
  logic [1:0]  rsize_q, rsize_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [3:0]  rid_q, rid_d;

  logic        w_idle, wr_done, wr_accept, rd_allowed, rd_data_busy;
  logic        data_rd_cand, rd_addr_ok, rd_data_ok, r_in_data, beat_match;
  logic [31:0] w_awaddr;

`ifdef RAW_ADDR_CHECK_EN
  assign rd_allowed = w_idle | (data_addr[31:2] != w_awaddr[31:2]);
`else
  assign rd_allowed = w_idle;
`endif

  assign data_rd_cand = data_req & ~data_wr & rd_allowed;
  assign rd_data_busy = (r_state_q != R_IDLE) & (rid_q == DATA_ID);
  assign r_in_data    = (r_state_q == R_DATA);
  // beats tagged with a foreign ID are consumed but never forwarded
  assign beat_match   = axi.rvalid & (axi.rid == rid_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rsize_q   <= '0;
      rlen_q    <= '0;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rsize_q   <= rsize_d;
      rlen_q    <= rlen_d;
      rid_q     <= rid_d;
    end
  end

  always_comb begin
    r_state_d    = r_state_q;
    raddr_d      = raddr_q;
    rsize_d      = rsize_q;
    rlen_d       = rlen_q;
    rid_d        = rid_q;
    inst_addr_ok = 1'b0;
    rd_addr_ok   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (data_rd_cand && (DATA_FIRST || !inst_req)) begin
          rd_addr_ok = 1'b1;
          raddr_d    = data_addr;
          rsize_d    = data_size;
          rlen_d     = 8'd0;
          rid_d      = DATA_ID;
          r_state_d  = R_AR;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          raddr_d      = inst_addr;
          rsize_d      = INST_SIZE;
          rlen_d       = inst_len;
          rid_d        = INST_ID;
          r_state_d    = R_AR;
        end
      end
      R_AR:    if (axi.arready) r_state_d = R_DATA;
      R_DATA:  if (beat_match && axi.rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  assign axi.arid    = rid_q;
  assign axi.araddr  = raddr_q;
  assign axi.arlen   = rlen_q;
  assign axi.arsize  = to_axsize(rsize_q);
  assign axi.arvalid = (r_state_q == R_AR);
  assign axi.rready  = r_in_data;

  assign inst_data_ok = r_in_data & beat_match & (rid_q == INST_ID);
  assign inst_rdata   = axi.rdata;
  assign inst_rlast   = inst_data_ok & axi.rlast;
  assign rd_data_ok   = r_in_data & beat_match & (rid_q == DATA_ID) & axi.rlast;

  assign wr_accept    = data_req & data_wr & w_idle & ~rd_data_busy;
  assign data_addr_ok = rd_addr_ok | wr_accept;
  assign data_data_ok = rd_data_ok | wr_done;
  assign data_rdata   = axi.rdata;
  assign axi.awaddr   = w_awaddr;

  axi_wr_chan u_wr_chan (
    .clk       (clk),
    .reset     (reset),
    .accept_i  (wr_accept),
    .addr_i    (data_addr),
    .size_i    (data_size),
    .wstrb_i   (data_wstrb),
    .wdata_i   (data_wdata),
    .b_hold_i  (rd_data_ok),
    .idle_o    (w_idle),
    .done_o    (wr_done),
    .awaddr_o  (w_awaddr),
    .awsize_o  (axi.awsize),
    .awvalid_o (axi.awvalid),
    .awready_i (axi.awready),
    .wdata_o   (axi.wdata),
    .wstrb_o   (axi.wstrb),
    .wvalid_o  (axi.wvalid),
    .wready_i  (axi.wready),
    .bvalid_i  (axi.bvalid),
    .bready_o  (axi.bready)
  );

endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb/tb_axi_req_arbiter.sv - directed self-checking bench for axi_req_arbiter
module tb_axi_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [7:0]  inst_len;
  logic        inst_addr_ok, inst_data_ok, inst_rlast;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int total = 0;
  int bad   = 0;

  axi_req_arbiter_if axi ();

  axi_req_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_len     (inst_len),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_rlast   (inst_rlast),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, axi.arvalid, 0);
    chk({tag, "_rready"}, axi.rready, 0);
    chk({tag, "_awvalid"}, axi.awvalid, 0);
    chk({tag, "_wvalid"}, axi.wvalid, 0);
    chk({tag, "_bready"}, axi.bready, 0);
    chk({tag, "_inst_data_ok"}, inst_data_ok, 0);
    chk({tag, "_data_data_ok"}, data_data_ok, 0);
  endtask

  initial begin
    reset = 1; inst_req = 0; inst_addr = 0; inst_len = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rlast = 0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    tick; tick; #1;
    chk_quiet("rst");
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_arlen", axi.arlen, 0);
    reset = 0;
    tick;

    // single data read
    data_req = 1; data_wr = 0; data_addr = 32'h1c000100; data_size = 2'd2; #1;
    chk("t1_data_addr_ok", data_addr_ok, 1);
    chk("t1_inst_addr_ok", inst_addr_ok, 0);
    tick;
    data_wr = 1; #1;
    chk("t1_wr_blocked", data_addr_ok, 0);
    chk("t1_arvalid", axi.arvalid, 1);
    chk("t1_arid", axi.arid, 1);
    chk("t1_arlen", axi.arlen, 0);
    chk("t1_araddr", axi.araddr, 32'h1c000100);
    chk("t1_arsize", axi.arsize, 2);
    tick;
    data_req = 0; data_wr = 0; axi.arready = 1; #1;
    chk("t1_arvalid_hold", axi.arvalid, 1);
    tick;
    axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'hdeadbeef; axi.rlast = 1; #1;
    chk("t1_rready", axi.rready, 1);
    chk("t1_data_data_ok", data_data_ok, 1);
    chk("t1_data_rdata", data_rdata, 32'hdeadbeef);
    chk("t1_inst_data_ok", inst_data_ok, 0);
    tick;

    // simultaneous inst and data read, data wins
    axi.rvalid = 0; axi.rlast = 0;
    inst_req = 1; inst_addr = 32'h1fc00000; inst_len = 0;
    data_req = 1; data_addr = 32'h1c000200; #1;
    chk("t2_idle_rready", axi.rready, 0);
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok", inst_addr_ok, 0);
    tick;
    data_req = 0; axi.arready = 1; #1;
    chk("t2_inst_wait", inst_addr_ok, 0);
    chk("t2_arid", axi.arid, 1);
    chk("t2_araddr", axi.araddr, 32'h1c000200);
    tick;
    axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'h11112222; axi.rlast = 1; #1;
    chk("t2_data_data_ok", data_data_ok, 1);
    chk("t2_inst_wait_rd", inst_addr_ok, 0);
    tick;
    axi.rvalid = 0; axi.rlast = 0; #1;
    chk("t2_inst_granted", inst_addr_ok, 1);
    tick;
    inst_req = 0; axi.arready = 1; #1;
    chk("t2_inst_arid", axi.arid, 0);
    chk("t2_inst_araddr", axi.araddr, 32'h1fc00000);
    chk("t2_inst_arlen", axi.arlen, 0);
    tick;
    axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hcafef00d; axi.rlast = 1; #1;
    chk("t2_inst_data_ok", inst_data_ok, 1);
    chk("t2_inst_rdata", inst_rdata, 32'hcafef00d);
    chk("t2_inst_rlast", inst_rlast, 1);
    chk("t2_no_data_ok", data_data_ok, 0);
    tick;

    // four-beat inst burst with a gap and a stray beat
    axi.rvalid = 0; axi.rlast = 0;
    inst_req = 1; inst_addr = 32'h1fc00040; inst_len = 8'd3; #1;
    chk("t3_inst_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 0; axi.arready = 1; #1;
    chk("t3_arlen", axi.arlen, 3);
    chk("t3_arsize", axi.arsize, 2);
    chk("t3_araddr", axi.araddr, 32'h1fc00040);
    tick;
    axi.arready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        axi.rvalid = 0; axi.rlast = 0; #1;
        chk("t3_gap_rready", axi.rready, 1);
        chk("t3_gap_ok", inst_data_ok, 0);
        tick;
        axi.rvalid = 1; axi.rid = 1; axi.rlast = 1; axi.rdata = 32'h0; #1;
        chk("t3_stray_data_ok", data_data_ok, 0);
        chk("t3_stray_inst_ok", inst_data_ok, 0);
        tick;
      end
      axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'ha0 + i; axi.rlast = (i == 3); #1;
      chk("t3_beat_rready", axi.rready, 1);
      chk("t3_beat_ok", inst_data_ok, 1);
      chk("t3_beat_rdata", inst_rdata, 32'ha0 + i);
      chk("t3_beat_rlast", inst_rlast, (i == 3) ? 1 : 0);
      tick;
    end
    axi.rvalid = 0; axi.rlast = 0; #1;
    chk("t3_done_rready", axi.rready, 0);

    // write, W handshakes three cycles before AW
    data_req = 1; data_wr = 1; data_addr = 32'h1c000300; data_size = 2'd2;
    data_wstrb = 4'hf; data_wdata = 32'h12345678; #1;
    chk("t4_addr_ok", data_addr_ok, 1);
    tick;
    data_req = 0; axi.wready = 1; axi.awready = 0; #1;
    chk("t4_awvalid", axi.awvalid, 1);
    chk("t4_wvalid", axi.wvalid, 1);
    chk("t4_awaddr", axi.awaddr, 32'h1c000300);
    chk("t4_wdata", axi.wdata, 32'h12345678);
    chk("t4_wstrb", axi.wstrb, 4'hf);
    chk("t4_awsize", axi.awsize, 2);
    tick;
    axi.wready = 0; #1;
    chk("t4_wvalid_drop1", axi.wvalid, 0);
    chk("t4_awvalid_hold1", axi.awvalid, 1);
    tick; #1;
    chk("t4_wvalid_drop2", axi.wvalid, 0);
    chk("t4_awvalid_hold2", axi.awvalid, 1);
    tick;
    axi.awready = 1; #1;
    chk("t4_awvalid_hold3", axi.awvalid, 1);
    chk("t4_bready_early", axi.bready, 0);
    tick;
    axi.awready = 0; #1;
    chk("t4_resp_awvalid", axi.awvalid, 0);
    chk("t4_resp_bready", axi.bready, 1);
    chk("t4_resp_no_ok", data_data_ok, 0);
    tick;
    axi.bvalid = 1; #1;
    chk("t4_b_ok", data_data_ok, 1);
    tick;
    axi.bvalid = 0; #1;
    chk("t4_idle_bready", axi.bready, 0);

    // data read arriving while a write waits for B
    data_req = 1; data_wr = 1; data_addr = 32'h1c000300; data_wdata = 32'h55aa55aa; #1;
    chk("t5_wr_addr_ok", data_addr_ok, 1);
    tick;
    data_req = 0; axi.awready = 1; axi.wready = 1; #1;
    chk("t5_awvalid", axi.awvalid, 1);
    chk("t5_wvalid", axi.wvalid, 1);
    tick;
    axi.awready = 0; axi.wready = 0;
    data_req = 1; data_wr = 0; data_addr = 32'h1c000400; #1;
`ifdef RAW_ADDR_CHECK_EN
    chk("t5_raw_rd_ok", data_addr_ok, 1);
    tick;
    data_req = 0; axi.arready = 1; #1;
    chk("t5_raw_arvalid", axi.arvalid, 1);
    tick;
    axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rlast = 1; axi.rdata = 32'h0badf00d;
    axi.bvalid = 1; #1;
    chk("t5_raw_bready_hold", axi.bready, 0);
    chk("t5_raw_rd_data_ok", data_data_ok, 1);
    chk("t5_raw_rdata", data_rdata, 32'h0badf00d);
    tick;
    axi.rvalid = 0; axi.rlast = 0; #1;
    chk("t5_raw_bready", axi.bready, 1);
    chk("t5_raw_b_ok", data_data_ok, 1);
    tick;
    axi.bvalid = 0; #1;
    chk("t5_raw_bready_idle", axi.bready, 0);
`else
    chk("t5_rd_blocked1", data_addr_ok, 0);
    chk("t5_bready", axi.bready, 1);
    tick; #1;
    chk("t5_rd_blocked2", data_addr_ok, 0);
    axi.bvalid = 1; #1;
    chk("t5_b_ok", data_data_ok, 1);
    chk("t5_rd_blocked3", data_addr_ok, 0);
    tick;
    axi.bvalid = 0; #1;
    chk("t5_rd_ok", data_addr_ok, 1);
    tick;
    data_req = 0; axi.arready = 1; #1;
    chk("t5_arvalid", axi.arvalid, 1);
    chk("t5_araddr", axi.araddr, 32'h1c000400);
    tick;
    axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rlast = 1; axi.rdata = 32'h0badf00d; #1;
    chk("t5_rd_data_ok", data_data_ok, 1);
    chk("t5_rdata", data_rdata, 32'h0badf00d);
    tick;
    axi.rvalid = 0; axi.rlast = 0; #1;
    chk("t5_rready_idle", axi.rready, 0);
`endif
    data_req = 0;

    // reset in the middle of a burst
    inst_req = 1; inst_addr = 32'h1fc00080; inst_len = 8'd3; #1;
    chk("t6_inst_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 0; axi.arready = 1;
    tick;
    axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rlast = 0; axi.rdata = 32'h1; #1;
    chk("t6_beat0", inst_data_ok, 1);
    tick;
    axi.rvalid = 0; reset = 1;
    tick;
    reset = 0; #1;
    chk_quiet("t6_post_rst");
    inst_req = 1; inst_addr = 32'h1fc000c0; inst_len = 8'd1; #1;
    chk("t6_new_addr_ok", inst_addr_ok, 1);
    tick;
    inst_req = 0; #1;
    chk("t6_new_arvalid", axi.arvalid, 1);
    chk("t6_new_arlen", axi.arlen, 1);
    chk("t6_new_araddr", axi.araddr, 32'h1fc000c0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
